// File: rtl/mips_muldiv.sv
// Iterative 32-bit MIPS multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the DIV/DIVU datapath; without it divide requests complete at once, leaving HI/LO untouched.
module mips_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        is_signed_s;
    logic [32:0] mul_sum_s;
    logic [63:0] prod_s;
`ifdef MULDIV_DIV_EN
    logic        div_q, div_d;
    logic        rem_neg_q, rem_neg_d;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
`endif

    assign is_signed_s = ~op[0];
    // Accumulator upper half plus the multiplicand when the current multiplier bit is set.
    assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : 33'd0);
    assign prod_s      = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_DIV_EN
    assign div_shift_s = {acc_hi_q, acc_lo_q[31]};
    assign div_diff_s  = div_shift_s - {1'b0, dvs_q};
    assign div_ge_s    = ~div_diff_s[32];
`endif

    // Next-state, datapath step and output-register decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    cnt_d    = 5'd0;
                    acc_hi_d = 32'd0;
                    acc_lo_d = abs32(operand_a, is_signed_s);
                    dvs_d    = abs32(operand_b, is_signed_s);
                    neg_d    = is_signed_s && (operand_a[31] ^ operand_b[31]);
`ifdef MULDIV_DIV_EN
                    div_d     = op[1];
                    rem_neg_d = is_signed_s && operand_a[31];
`endif
                    if (op[1]) begin
`ifdef MULDIV_DIV_EN
                        if (operand_b == 32'd0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            dbz_d   = 1'b1;
                            hi_d    = operand_a;
                            lo_d    = 32'hFFFF_FFFF;
                        end else begin
                            state_d = ST_RUN;
                            busy_d  = 1'b1;
                        end
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    if (hi_we) hi_d = wdata; else hi_d = hi_q;
                    if (lo_we) lo_d = wdata; else lo_d = lo_q;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    acc_hi_d = div_ge_s ? div_diff_s[31:0] : div_shift_s[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge_s};
                end else begin
                    acc_hi_d = mul_sum_s[32:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[31:1]};
                end
`else
                acc_hi_d = mul_sum_s[32:1];
                acc_lo_d = {mul_sum_s[0], acc_lo_q[31:1]};
`endif
                if (cnt_q == 5'd31) state_d = ST_FIX; else state_d = ST_RUN;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    lo_d = neg_q     ? (32'd0 - acc_lo_q) : acc_lo_q;
                    hi_d = rem_neg_q ? (32'd0 - acc_hi_q) : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? (64'd0 - prod_s) : prod_s;
                end
`else
                {hi_d, lo_d} = neg_q ? (64'd0 - prod_s) : prod_s;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            dvs_q     <= 32'd0;
            neg_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus random operations
// compared against a plain-arithmetic model of HI/LO, latency and the divide-by-zero flag.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;

    always #5 clk = ~clk;

    mips_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected HI/LO, flag and edges from acceptance to the done pulse.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo,
                         output logic edbz, output int elat);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        edbz = 1'b0;
        elat = 33;
        ehi  = hi_m;
        elo  = lo_m;
        case (o)
            2'b00: begin
                p = sa * sb;
                ehi = p[63:32];
                elo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                ehi = p[63:32];
                elo = p[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    elat = 0;
                    edbz = 1'b1;
                    ehi  = a;
                    elo  = 32'hFFFF_FFFF;
                end else begin : divide
                    longint q;
                    longint r;
                    if (o == 2'b11) begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q   = sa / sb;
                    r   = sa % sb;
                    elo = q[31:0];
                    ehi = r[31:0];
                end
`else
                elat = 0;
`endif
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit skip_wait, input bit mid_start, input bit we_busy, input bit we_start);
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
        int          elat;
        int          cyc;
        bit          seen;
        bit          busy_bad;
        model(o, a, b, ehi, elo, edbz, elat);
        if (!skip_wait) @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        if (we_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        if (we_start && elat != 0) begin
            chk("we_dropped_hi", hi, hi_m);
            chk("we_dropped_lo", lo, lo_m);
        end
        cyc = 0; seen = 1'b0; busy_bad = 1'b0;
        while (!seen && cyc < 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad = 1'b1;
                if (we_busy && cyc == 9) chk("hi_unchanged_busy", hi, hi_m);
                start = mid_start && (cyc == 5);
                if (start) begin
                    op = ~o; operand_a = ~a; operand_b = b + 32'd1;
                end
                hi_we = we_busy && (cyc == 7);
                wdata = 32'hDEAD_BEEF;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; hi_we = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", cyc, elat);
        chk("busy_while_running", busy_bad, 0);
        chk("busy_at_done", busy, 0);
        chk("hi", hi, ehi);
        chk("lo", lo, elo);
        chk("div_by_zero", div_by_zero, edbz);
        hi_m = ehi;
        lo_m = elo;
        @(negedge clk);
        chk("done_pulse_width", done, 0);
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
        chk("mt_hi", hi, hi_m);
        chk("mt_lo", lo, lo_m);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; operand_a = 32'd0; operand_b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, 0);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, 0, 0, 0);
        run_op(2'b10, 32'h1234_5678, 32'h0000_0000, 0, 0, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        mt(1'b1, 1'b0, 32'hCAFE_F00D);
        mt(1'b0, 1'b1, 32'h1357_2468);
        run_op(2'b00, 32'h0000_1234, 32'hFFFF_FF00, 0, 0, 1, 0);
        run_op(2'b01, 32'h0000_0003, 32'h0000_0005, 0, 0, 0, 1);
        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 0, 0, 0, 1);

        // Abort a multiply at counter 10, then start again on the first edge after release.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand_a = 32'h0000_7777; operand_b = 32'h0000_0011;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        rst = 1'b1;
        run_op(2'b01, 32'h0001_0001, 32'h0000_FFFF, 1, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            op_r = 2'($urandom_range(0, 3));
            a_r  = $urandom;
            b_r  = $urandom;
            case ($urandom_range(0, 5))
                0:       b_r = 32'd0;
                1:       a_r = 32'h8000_0000;
                2:       b_r = 32'hFFFF_FFFF;
                3:       b_r = 32'($urandom_range(1, 9));
                default: b_r = b_r;
            endcase
            run_op(op_r, a_r, b_r, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 start  input  1  request a new operation; sampled on rising edge of clk.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_a  input  32  rs value, from register-file read_data1; sampled with start.
REQ-007 operand_b  input  32  rt value, from register-file read_data2; sampled with start.
REQ-008 hi_we / lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 wdata  input  32  data for MTHI / MTLO.
REQ-010 busy  output  1  operation in progress; new start ignored.
REQ-011 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 div_by_zero  output  1  valid with done; set when a DIV/DIVU had operand_b == 0.
REQ-013 hi / lo  output  32 each  architectural HI and LO registers (MFHI/MFLO source).

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX and DONE; busy = 1 in RUN and FIX only; done = 1 in DONE only.
REQ-015 start SHALL be accepted only in IDLE or DONE; start in RUN or FIX is ignored and operands are not resampled.
REQ-016 On acceptance (edge N) the block SHALL latch op, |a| and |b| (absolute values for signed ops, raw values for unsigned), the result signs and a 5-bit counter = 0; then go to RUN.
REQ-017 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per edge, for exactly 32 edges (counter 0..31); on counter 31 go to FIX.
REQ-018 FIX SHALL apply the sign correction, write HI/LO on the exit edge (N+33) and go to DONE; DONE lasts one cycle and returns to IDLE unless a new start is accepted.
REQ-019 Multiply SHALL give {HI,LO} = 64-bit product; signed product is negative iff exactly one operand is negative.
REQ-020 Divide SHALL give LO = quotient and HI = remainder; quotient truncates toward zero; remainder takes the sign of operand_a.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0 with no flag.
REQ-022 DIV/DIVU with operand_b == 0 SHALL skip RUN/FIX: next edge goes to DONE with LO = 0xFFFFFFFF, HI = operand_a and div_by_zero = 1.
REQ-023 div_by_zero SHALL be 0 at every done pulse except the case in REQ-022.
REQ-024 hi_we / lo_we SHALL write wdata to hi / lo on the edge when state is IDLE or DONE and no start is accepted on that edge.
REQ-025 A start accepted on the same edge as hi_we / lo_we SHALL take priority; the writes are dropped.
REQ-026 hi_we / lo_we SHALL be ignored while busy.
REQ-027 hi and lo SHALL stay unchanged between result writes and MTHI/MTLO writes.

Reset
REQ-028 rst = 0 SHALL immediately force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0 and counter = 0, independent of clk.
REQ-029 Reset during RUN or FIX SHALL abort the operation with no done pulse; the first edge after rst rises SHALL accept a start.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: DIV and DIVU SHALL be implemented as specified.
REQ-031 Macro MULDIV_DIV_EN undefined: the divider datapath SHALL be absent; DIV/DIVU starts go to DONE on the next edge with hi/lo unchanged and div_by_zero = 0. MULT/MULTU are unaffected.

Verification
REQ-032 MULT a = 0xFFFFFFFF, b = 0x00000002 -> done at cycle N+33, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; busy high during cycles N+1..N+32.
REQ-033 MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; a second start pulsed mid-RUN is ignored (exactly one done).
REQ-034 DIV a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU a = 7, b = 2 -> LO = 3, HI = 1.
REQ-035 DIV a = 0x12345678, b = 0 -> done one cycle after start, div_by_zero = 1, LO = 0xFFFFFFFF, HI = 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-036 MTHI wdata = 0xCAFEF00D in IDLE -> hi = 0xCAFEF00D; hi_we while busy -> hi unchanged; rst = 0 at counter 10 -> hi = lo = 0, busy = 0, no done pulse.
